// File: rtl/bexkat1Def.sv
// bexkat1Def: shared instruction types and memory-stage definitions
package bexkat1Def;
  localparam logic [3:0] T_ALU = 4'h0;
  localparam logic [3:0] T_LOAD = 4'h7;
  localparam logic [3:0] T_STORE = 4'h8;
  localparam logic [7:0] MEM_TIMEOUT = 8'd255;
  typedef enum logic [1:0] {SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10, SZ_WORDX = 2'b11} memsize_t;
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} memstate_t;
  function automatic logic is_aligned(memsize_t sz, logic [1:0] a);
    return sz == SZ_BYTE || (sz == SZ_HALF ? !a[0] : a == 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane.sv
// mem_lane: big-endian byte-lane steering for sel, store replication and load extraction
module mem_lane
  import bexkat1Def::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  adr,
  input  logic [31:0] wdata,
  input  logic [31:0] rraw,
  output logic [3:0]  sel,
  output logic [31:0] wdat,
  output logic [31:0] rdat
);
  logic [31:0] bsh;
  assign bsh = rraw >> {~adr, 3'b000};
  assign sel = size == SZ_BYTE ? 4'b1000 >> adr : size == SZ_HALF ? (adr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign wdat = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  assign rdat = size == SZ_BYTE ? {24'd0, bsh[7:0]} : size == SZ_HALF ? {16'd0, adr[1] ? rraw[15:0] : rraw[31:16]} : rraw;
endmodule

// File: rtl/memaccess.sv
// memaccess: memory pipeline stage driving a Wishbone-style master with timeout and stall handling
module memaccess
  import bexkat1Def::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] result_i,
  input  logic [31:0] reg_data1_i,
  input  logic [1:0]  reg_write_i,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic [31:0] result_o,
  output logic [1:0]  reg_write_o,
  input  logic        stall_i,
  output logic        stall_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  output logic        fault_o
);
  memstate_t state;
  memsize_t size;
  logic [7:0] cnt;
  logic [31:0] dat_q, wdat, rdat;
  logic [3:0] sel;
  logic err_q, is_load, mem_op, accept, tmo, fin, ld_ok;
  assign size = memsize_t'(ir_i[25:24]);
  assign is_load = ir_i[31:28] == T_LOAD;
  assign mem_op = is_load || ir_i[31:28] == T_STORE;
  assign accept = mem_op && is_aligned(size, result_i[1:0]);
  assign tmo = state == S_BUS && !bus_ack_i && cnt == MEM_TIMEOUT - 8'd1;
  assign fin = state == S_DONE || (state == S_BUS && (bus_ack_i || tmo));
  assign ld_ok = is_load && !(state == S_DONE ? err_q : tmo);
  // completion cycles release execute so the finished op is not re-issued
  assign stall_o = stall_i || (state == S_IDLE ? accept : !fin);
  mem_lane u_lane (
    .size  (size),
    .adr   (result_i[1:0]),
    .wdata (reg_data1_i),
    .rraw  (state == S_DONE ? dat_q : bus_dat_i),
    .sel   (sel),
    .wdat  (wdat),
    .rdat  (rdat)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      cnt <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
      ir_o <= '0;
      pc_o <= '0;
      result_o <= '0;
      reg_write_o <= '0;
      fault_o <= 1'b0;
      bus_cyc_o <= 1'b0;
      bus_stb_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_adr_o <= '0;
      bus_sel_o <= '0;
      bus_dat_o <= '0;
    end else begin
      fault_o <= 1'b0;
      if (fin) begin
        bus_cyc_o <= 1'b0;
        bus_stb_o <= 1'b0;
        bus_we_o <= 1'b0;
        bus_sel_o <= '0;
        fault_o <= tmo;
      end
      if (fin && !stall_i) begin
        state <= S_IDLE;
        ir_o <= ir_i;
        pc_o <= pc_i;
        result_o <= ld_ok ? rdat : result_i;
        reg_write_o <= ld_ok ? 2'b11 : 2'b00;
      end else if (fin && state == S_BUS) begin
        state <= S_DONE;
        dat_q <= bus_dat_i;
        err_q <= tmo;
      end else if (state == S_BUS) begin
        cnt <= cnt + 8'd1;
        if (!stall_i) begin
          ir_o <= '0;
          reg_write_o <= '0;
        end
      end else if (state == S_IDLE && !stall_i) begin
        if (accept) begin
          state <= S_BUS;
          cnt <= '0;
          bus_cyc_o <= 1'b1;
          bus_stb_o <= 1'b1;
          bus_we_o <= !is_load;
          bus_adr_o <= {result_i[31:2], 2'b00};
          bus_sel_o <= sel;
          bus_dat_o <= wdat;
          ir_o <= '0;
          reg_write_o <= '0;
        end else begin
          ir_o <= ir_i;
          pc_o <= pc_i;
          result_o <= result_i;
          reg_write_o <= mem_op ? 2'b00 : reg_write_i;
          fault_o <= mem_op;
        end
      end
    end
  end
endmodule

// File: tb/tb_memaccess.sv
// tb_memaccess: directed and randomized checks of memaccess against a byte-level reference model
module tb_memaccess;
  import bexkat1Def::*;
  logic clk_i, rst_ni, stall_i, stall_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_ack_i, fault_o;
  logic [63:0] ir_i, ir_o;
  logic [31:0] pc_i, result_i, reg_data1_i, pc_o, result_o, bus_adr_o, bus_dat_o, bus_dat_i;
  logic [1:0] reg_write_i, reg_write_o;
  logic [3:0] bus_sel_o;
  int checks = 0, errors = 0;

  memaccess dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ir_i(ir_i), .pc_i(pc_i), .result_i(result_i),
    .reg_data1_i(reg_data1_i), .reg_write_i(reg_write_i), .ir_o(ir_o), .pc_o(pc_o),
    .result_o(result_o), .reg_write_o(reg_write_o), .stall_i(stall_i), .stall_o(stall_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i),
    .fault_o(fault_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int nb(logic [1:0] sz);
    return sz == 2'b10 ? 1 : sz == 2'b01 ? 2 : 4;
  endfunction

  // byte k of the access lives at address offset a+k, which is bit lane 3-(a+k)
  function automatic logic [3:0] ref_sel(logic [1:0] sz, logic [1:0] a);
    ref_sel = '0;
    for (int k = 0; k < nb(sz); k++) ref_sel[3 - (int'(a) + k)] = 1'b1;
  endfunction

  function automatic logic [31:0] ref_wdat(logic [1:0] sz, logic [31:0] d);
    int n;
    n = nb(sz);
    ref_wdat = '0;
    for (int l = 0; l < 4; l++) ref_wdat[8*(3-l) +: 8] = 8'((d >> (8 * (n - 1 - (l % n)))) & 32'hff);
  endfunction

  function automatic logic [31:0] ref_rdat(logic [1:0] sz, logic [1:0] a, logic [31:0] d);
    ref_rdat = '0;
    for (int k = 0; k < nb(sz); k++) ref_rdat = (ref_rdat << 8) | ((d >> (8 * (3 - (int'(a) + k)))) & 32'hff);
  endfunction

  // waits: no-ack bus cycles before ack (negative = never ack); ack_stall: cycles stall_i held from the ack
  task automatic do_op(input logic [3:0] typ, input logic [1:0] sz, input logic [31:0] adr,
                       input logic [31:0] wd, input logic [31:0] rd, input int waits, input int ack_stall);
    logic [63:0] ir;
    logic [31:0] pc;
    logic mem, ld, mis;
    int n, sc;
    ir = {$urandom, $urandom};
    ir[31:28] = typ;
    ir[25:24] = sz;
    pc = $urandom;
    mem = typ == T_LOAD || typ == T_STORE;
    ld = typ == T_LOAD;
    mis = mem && ((sz == 2'b01 && adr[0]) || (sz != 2'b01 && sz != 2'b10 && adr[1:0] != 2'b00));
    ir_i = ir; pc_i = pc; result_i = adr; reg_data1_i = wd; reg_write_i = 2'b11;
    stall_i = 1'b0; bus_ack_i = 1'b0; bus_dat_i = $urandom;
    #1;
    check("stall_req", 64'(stall_o), 64'(mem && !mis));
    sc = int'(stall_o);
    tick();
    if (!mem || mis) begin
      check("pass_ir", ir_o, ir);
      check("pass_pc", 64'(pc_o), 64'(pc));
      check("pass_result", 64'(result_o), 64'(adr));
      check("pass_rw", 64'(reg_write_o), mem ? 64'd0 : 64'd3);
      check("pass_fault", 64'(fault_o), 64'(mis));
      check("pass_nocyc", 64'(bus_cyc_o), 64'd0);
    end else begin
      check("bus_cyc_stb", 64'({bus_cyc_o, bus_stb_o}), 64'd3);
      check("bus_we", 64'(bus_we_o), 64'(!ld));
      check("bus_adr", 64'(bus_adr_o), 64'({adr[31:2], 2'b00}));
      check("bus_sel", 64'(bus_sel_o), 64'(ref_sel(sz, adr[1:0])));
      if (!ld) check("bus_dat", 64'(bus_dat_o), 64'(ref_wdat(sz, wd)));
      check("bubble_ir", ir_o, 64'd0);
      check("bubble_rw", 64'(reg_write_o), 64'd0);
      if (waits < 0) begin
        n = 0;
        while (bus_cyc_o && n < 300) begin
          n++;
          tick();
        end
        check("tmo_cycles", 64'(n), 64'd255);
        check("tmo_fault", 64'(fault_o), 64'd1);
        check("tmo_ir", ir_o, ir);
        check("tmo_rw", 64'(reg_write_o), 64'd0);
      end else begin
        for (int w = 0; w < waits; w++) begin
          sc += int'(stall_o);
          tick();
          check("wait_hold", 64'({bus_cyc_o, bus_stb_o, bus_sel_o, bus_adr_o}),
                64'({2'b11, ref_sel(sz, adr[1:0]), adr[31:2], 2'b00}));
        end
        check("stall_cnt", 64'(sc), 64'(waits + 1));
        bus_ack_i = 1'b1; bus_dat_i = rd; stall_i = ack_stall > 0;
        #1;
        check("ack_stall_o", 64'(stall_o), 64'(ack_stall > 0));
        tick();
        bus_ack_i = 1'b0; bus_dat_i = $urandom;
        if (ack_stall > 0) begin
          check("done_nocyc", 64'(bus_cyc_o), 64'd0);
          check("done_hold_ir", ir_o, 64'd0);
          for (int s = 1; s < ack_stall; s++) tick();
          stall_i = 1'b0;
          tick();
        end
        check("ack_ir", ir_o, ir);
        check("ack_pc", 64'(pc_o), 64'(pc));
        check("ack_result", 64'(result_o), ld ? 64'(ref_rdat(sz, adr[1:0], rd)) : 64'(adr));
        check("ack_rw", 64'(reg_write_o), ld ? 64'd3 : 64'd0);
        check("ack_nocyc", 64'(bus_cyc_o), 64'd0);
      end
    end
    stall_i = 1'b1;
    tick();
    check("hold_ir", ir_o, ir);
    check("fault_pulse", 64'(fault_o), 64'd0);
    stall_i = 1'b0;
  endtask

  initial begin
    logic [3:0] t;
    logic [31:0] a;
    int r;
    rst_ni = 1'b0; ir_i = '0; pc_i = '0; result_i = '0; reg_data1_i = '0; reg_write_i = '0;
    stall_i = 1'b0; bus_ack_i = 1'b0; bus_dat_i = '0;
    tick();
    tick();
    check("rst_outs", 64'({ir_o, pc_o, result_o, reg_write_o}), 64'd0);
    check("rst_bus", 64'({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, fault_o}), 64'd0);
    rst_ni = 1'b1;
    do_op(T_ALU, 2'b00, 32'h1234, 32'h0, 32'h0, 0, 0);
    do_op(T_LOAD, 2'b10, 32'h1001, 32'h0, 32'hAABBCCDD, 3, 0);
    do_op(T_STORE, 2'b01, 32'h2002, 32'h0000BEEF, 32'h0, 1, 0);
    do_op(T_LOAD, 2'b00, 32'h3001, 32'h0, 32'h0, 0, 0);
    do_op(T_LOAD, 2'b00, 32'h4000, 32'h0, 32'h0, -1, 0);
    do_op(T_LOAD, 2'b00, 32'h5000, 32'h0, 32'h12345678, 2, 5);
    ir_i = '0; ir_i[31:28] = T_LOAD; result_i = 32'h6000; stall_i = 1'b0; bus_ack_i = 1'b0;
    tick();
    tick();
    check("pre_rst_cyc", 64'(bus_cyc_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_bus", 64'({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, fault_o}), 64'd0);
    check("arst_outs", 64'({ir_o, pc_o, result_o, reg_write_o}), 64'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    do_op(T_LOAD, 2'b01, 32'h7002, 32'h0, 32'h89ABCDEF, 1, 0);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      t = r == 0 ? T_ALU : r == 1 ? T_LOAD : r == 2 ? T_STORE : 4'h3;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_op(t, 2'($urandom_range(0, 3)), a, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
